// File: rtl/key_entry_encoder.sv
// key_entry_encoder: synchronizes and debounces the store/input/submit buttons and sequences
// PASS_LEN-symbol entries into one-cycle strobes. Macro ENTRY_TIMEOUT_EN adds an idle-entry abort.
module key_entry_encoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PASS_LEN        = 4,
   parameter int TIMEOUT_CYCLES  = 250000000
) (
   input  logic       clk,
   input  logic       system_reset,
   input  logic       store_btn,
   input  logic       input_btn,
   input  logic       submit_btn,
   input  logic [1:0] sw_bits,
   output logic [1:0] bits,
   output logic       store_value,
   output logic       input_value,
   output logic       compare,
   output logic       input_reset,
   output logic       entry_error,
   output logic [2:0] sym_count,
   output logic       stored_valid
);

   localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [2:0]    PLEN    = 3'(PASS_LEN);

   typedef enum logic [1:0] {IDLE = 2'd0, STORING = 2'd1, ENTERING = 2'd2} state_t;

   state_t        state, state_next;
   logic [2:0]    btn_raw, btn_meta, btn_sync, btn_deb, btn_deb_d, press;
   logic [1:0]    sw_meta, sw_sync;
   logic [DW-1:0] db_cnt [3];
   logic          multi, timeout;
   logic [2:0]    cnt_next;
   logic [1:0]    bits_next;
   logic          valid_next, sv_next, iv_next, cmp_next, ir_next, err_next;

   // Bit order everywhere: [2]=store, [1]=input, [0]=submit.
   assign btn_raw = {store_btn, input_btn, submit_btn};
   assign multi   = (press[2] & press[1]) | (press[2] & press[0]) | (press[1] & press[0]);

   always_ff @(posedge clk) begin
      if (system_reset) begin
         btn_meta  <= 3'b000;
         btn_sync  <= 3'b000;
         btn_deb   <= 3'b000;
         btn_deb_d <= 3'b000;
         press     <= 3'b000;
         sw_meta   <= 2'b00;
         sw_sync   <= 2'b00;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         btn_meta  <= btn_raw;
         btn_sync  <= btn_meta;
         sw_meta   <= sw_bits;
         sw_sync   <= sw_meta;
         btn_deb_d <= btn_deb;
         press     <= btn_deb & ~btn_deb_d;
         // Count consecutive cycles of disagreement; any agreement restarts the count.
         for (int i = 0; i < 3; i++) begin
            if (btn_sync[i] == btn_deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_deb[i] <= btn_sync[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
         end
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);
   logic [TW-1:0] to_cnt;

   assign timeout = (state != IDLE) && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (system_reset || state == IDLE || press != 3'b000 || timeout) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TO_ONE;
      end
   end
`else
   // Timeout disabled: the parameter is only referenced to keep one interface for both builds.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_next = state;
      cnt_next   = sym_count;
      valid_next = stored_valid;
      bits_next  = bits;
      sv_next    = 1'b0;
      iv_next    = 1'b0;
      cmp_next   = 1'b0;
      ir_next    = 1'b0;
      err_next   = 1'b0;
      if (multi) begin
         err_next = 1'b1;
      end else if (press != 3'b000) begin
         case (state)
            IDLE: begin
               if (press[2]) begin
                  sv_next   = 1'b1;
                  bits_next = sw_sync;
                  if (PLEN == 3'd1) begin
                     valid_next = 1'b1;
                     cnt_next   = 3'd0;
                  end else begin
                     cnt_next   = 3'd1;
                     state_next = STORING;
                  end
               end else if (press[1]) begin
                  iv_next    = 1'b1;
                  bits_next  = sw_sync;
                  cnt_next   = 3'd1;
                  state_next = ENTERING;
               end else begin
                  err_next = 1'b1;
               end
            end
            STORING: begin
               if (press[2]) begin
                  sv_next   = 1'b1;
                  bits_next = sw_sync;
                  if (sym_count + 3'd1 == PLEN) begin
                     valid_next = 1'b1;
                     cnt_next   = 3'd0;
                     state_next = IDLE;
                  end else begin
                     cnt_next = sym_count + 3'd1;
                  end
               end else begin
                  err_next = 1'b1;
               end
            end
            ENTERING: begin
               if (press[1]) begin
                  if (sym_count < PLEN) begin
                     iv_next   = 1'b1;
                     bits_next = sw_sync;
                     cnt_next  = sym_count + 3'd1;
                  end else begin
                     err_next = 1'b1;
                  end
               end else if (press[0]) begin
                  if (sym_count == PLEN) begin
                     cmp_next = 1'b1;
                  end else begin
                     ir_next  = 1'b1;
                     err_next = 1'b1;
                  end
                  cnt_next   = 3'd0;
                  state_next = IDLE;
               end else begin
                  err_next = 1'b1;
               end
            end
            default: begin
               cnt_next   = 3'd0;
               state_next = IDLE;
            end
         endcase
      end else if (timeout) begin
         // An abandoned input entry also tells the checker to drop its partial symbols.
         ir_next    = (state == ENTERING);
         err_next   = 1'b1;
         cnt_next   = 3'd0;
         state_next = IDLE;
      end else begin
         state_next = state;
      end
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         state        <= IDLE;
         sym_count    <= 3'd0;
         stored_valid <= 1'b0;
         bits         <= 2'b00;
         store_value  <= 1'b0;
         input_value  <= 1'b0;
         compare      <= 1'b0;
         input_reset  <= 1'b0;
         entry_error  <= 1'b0;
      end else begin
         state        <= state_next;
         sym_count    <= cnt_next;
         stored_valid <= valid_next;
         bits         <= bits_next;
         store_value  <= sv_next;
         input_value  <= iv_next;
         compare      <= cmp_next;
         input_reset  <= ir_next;
         entry_error  <= err_next;
      end
   end

endmodule

// File: tb/tb_key_entry_encoder.sv
// tb_key_entry_encoder: directed vector table, reset corner cases and randomized presses
// checked against an abstract entry model (DEBOUNCE_CYCLES=4, PASS_LEN=4).
module tb_key_entry_encoder;

   localparam int DB = 4;
   localparam int PL = 4;
   localparam int LAT = DB + 3;

   logic       clk = 1'b0;
   logic       system_reset;
   logic       store_btn, input_btn, submit_btn;
   logic [1:0] sw_bits;
   logic [1:0] bits;
   logic       store_value, input_value, compare, input_reset, entry_error;
   logic [2:0] sym_count;
   logic       stored_valid;

   int tests = 0;
   int fails = 0;

   key_entry_encoder #(.DEBOUNCE_CYCLES(DB), .PASS_LEN(PL), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .system_reset(system_reset),
      .store_btn(store_btn), .input_btn(input_btn), .submit_btn(submit_btn),
      .sw_bits(sw_bits), .bits(bits),
      .store_value(store_value), .input_value(input_value), .compare(compare),
      .input_reset(input_reset), .entry_error(entry_error),
      .sym_count(sym_count), .stored_valid(stored_valid)
   );

   always #5 clk = ~clk;

   // Strobe vector order: {store_value, input_value, compare, input_reset, entry_error}.
   typedef struct {
      logic [2:0] mask;
      logic [1:0] sw;
      int         hold;
      logic [4:0] exp_s;
      logic [1:0] exp_bits;
      logic [2:0] exp_cnt;
      logic       exp_valid;
      string      name;
   } vec_t;

   vec_t vecs[$];

   // Abstract model: what the user is doing and how many symbols they have entered.
   int         m_mode;   // 0 nothing in progress, 1 storing a password, 2 typing a guess
   int         m_cnt;
   logic       m_valid;
   logic [1:0] m_bits;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add(input logic [2:0] m, input logic [1:0] sw, input int h, input logic [4:0] s,
                      input logic [1:0] b, input logic [2:0] c, input logic v, input string n);
      vec_t t;
      t.mask = m; t.sw = sw; t.hold = h; t.exp_s = s;
      t.exp_bits = b; t.exp_cnt = c; t.exp_valid = v; t.name = n;
      vecs.push_back(t);
   endtask

   function automatic void model_press(input logic [2:0] mask, input logic [1:0] sw, output logic [4:0] s);
      s = 5'b00000;
      if (mask == 3'b000) begin
         s = 5'b00000;
      end else if ($countones(mask) > 1) begin
         s = 5'b00001;
      end else if (mask == 3'b100) begin
         if (m_mode == 2) s = 5'b00001;
         else begin
            s = 5'b10000; m_bits = sw; m_cnt = m_cnt + 1; m_mode = 1;
            if (m_cnt == PL) begin m_valid = 1'b1; m_cnt = 0; m_mode = 0; end
         end
      end else if (mask == 3'b010) begin
         if (m_mode == 1 || m_cnt == PL) s = 5'b00001;
         else begin s = 5'b01000; m_bits = sw; m_cnt = m_cnt + 1; m_mode = 2; end
      end else begin
         if (m_mode != 2) s = 5'b00001;
         else begin
            s = (m_cnt == PL) ? 5'b00100 : 5'b00011;
            m_cnt = 0; m_mode = 0;
         end
      end
   endfunction

   // Called #1 after a posedge: the next posedge is the first to sample the raw press.
   task automatic apply(input vec_t v);
      logic [4:0] got, at_lat;
      int stray;
      stray = 0;
      at_lat = 5'b00000;
      {store_btn, input_btn, submit_btn} = v.mask;
      sw_bits = v.sw;
      for (int k = 0; k < v.hold + 12; k++) begin
         @(posedge clk); #1;
         got = {store_value, input_value, compare, input_reset, entry_error};
         if (k == LAT) at_lat = got;
         else if (got != 5'b00000) stray++;
         if (k == v.hold - 1) {store_btn, input_btn, submit_btn} = 3'b000;
      end
      check({v.name, " strobe"}, 8'(at_lat), 8'(v.exp_s));
      check({v.name, " stray"}, 8'(stray), 8'd0);
      check({v.name, " bits"}, 8'(bits), 8'(v.exp_bits));
      check({v.name, " count"}, 8'(sym_count), 8'(v.exp_cnt));
      check({v.name, " valid"}, 8'(stored_valid), 8'(v.exp_valid));
   endtask

   initial begin
      vec_t v;
      logic [4:0] s;
      int r, ir_seen;
      system_reset = 1'b1;
      {store_btn, input_btn, submit_btn} = 3'b000;
      sw_bits = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      system_reset = 1'b0;
      check("reset outputs", {1'b0, bits, store_value, input_value, compare, input_reset, entry_error}, 8'd0);
      check("reset count", 8'(sym_count), 8'd0);
      check("reset valid", 8'(stored_valid), 8'd0);

      add(3'b010, 2'd2, 10, 5'b01000, 2'd2, 3'd1, 1'b0, "first_input");
      add(3'b010, 2'd3, 3,  5'b00000, 2'd2, 3'd1, 1'b0, "glitch");
      add(3'b001, 2'd0, 6,  5'b00011, 2'd2, 3'd0, 1'b0, "early_submit");
      add(3'b100, 2'd3, 6,  5'b10000, 2'd3, 3'd1, 1'b0, "store1");
      add(3'b100, 2'd1, 6,  5'b10000, 2'd1, 3'd2, 1'b0, "store2");
      add(3'b010, 2'd2, 6,  5'b00001, 2'd1, 3'd2, 1'b0, "input_while_storing");
      add(3'b100, 2'd0, 6,  5'b10000, 2'd0, 3'd3, 1'b0, "store3");
      add(3'b100, 2'd2, 4,  5'b10000, 2'd2, 3'd0, 1'b1, "store4_min_hold");
      add(3'b010, 2'd1, 6,  5'b01000, 2'd1, 3'd1, 1'b1, "in1");
      add(3'b010, 2'd2, 6,  5'b01000, 2'd2, 3'd2, 1'b1, "in2");
      add(3'b010, 2'd3, 6,  5'b01000, 2'd3, 3'd3, 1'b1, "in3");
      add(3'b010, 2'd0, 6,  5'b01000, 2'd0, 3'd4, 1'b1, "in4");
      add(3'b010, 2'd1, 6,  5'b00001, 2'd0, 3'd4, 1'b1, "in5_full");
      add(3'b001, 2'd0, 6,  5'b00100, 2'd0, 3'd0, 1'b1, "submit_full");
      add(3'b010, 2'd3, 6,  5'b01000, 2'd3, 3'd1, 1'b1, "short_in1");
      add(3'b010, 2'd2, 6,  5'b01000, 2'd2, 3'd2, 1'b1, "short_in2");
      add(3'b001, 2'd0, 6,  5'b00011, 2'd2, 3'd0, 1'b1, "short_submit");
      add(3'b110, 2'd1, 6,  5'b00001, 2'd2, 3'd0, 1'b1, "simultaneous");
      add(3'b001, 2'd1, 6,  5'b00001, 2'd2, 3'd0, 1'b1, "idle_submit");
      add(3'b010, 2'd1, 6,  5'b01000, 2'd1, 3'd1, 1'b1, "pre_reset_in1");
      add(3'b010, 2'd0, 6,  5'b01000, 2'd0, 3'd2, 1'b1, "pre_reset_in2");
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Reset in the middle of an entry: everything clears and no input_reset is emitted.
      system_reset = 1'b1;
      @(posedge clk); #1;
      check("midreset outputs", {1'b0, bits, store_value, input_value, compare, input_reset, entry_error}, 8'd0);
      check("midreset count", 8'(sym_count), 8'd0);
      check("midreset valid", 8'(stored_valid), 8'd0);
      system_reset = 1'b0;
      ir_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (input_reset) ir_seen++;
      end
      check("midreset no input_reset", 8'(ir_seen), 8'd0);

      m_mode = 0; m_cnt = 0; m_valid = 1'b0; m_bits = 2'b00;
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3) v.mask = 3'b100;
         else if (r < 6) v.mask = 3'b010;
         else if (r < 8) v.mask = 3'b001;
         else if (r == 8) v.mask = (($urandom_range(0, 1) == 0) ? 3'b011 : 3'b101);
         else v.mask = 3'b000;
         case ($urandom_range(0, 4))
            0: v.hold = 2;
            1: v.hold = 3;
            2: v.hold = 4;
            3: v.hold = 6;
            default: v.hold = 9;
         endcase
         v.sw = 2'($urandom_range(0, 3));
         if (v.hold >= DB) model_press(v.mask, v.sw, s);
         else s = 5'b00000;
         v.exp_s = s;
         v.exp_bits = m_bits;
         v.exp_cnt = 3'(m_cnt);
         v.exp_valid = m_valid;
         v.name = $sformatf("rand%0d", n);
         apply(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
